// File: rtl/vga_pkg.sv
// Shared frame-buffer constants, grant encodings and address helpers.
// Also used by the VGA timing controller.
package vga_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int ADDR_W    = 19;
  localparam int LINE_W    = 9;
  localparam int OFFS_W    = 10;
  localparam int PIX_W     = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_CLR  = 2'd3
  } gnt_t;

  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    fb_addr_t          addr;
    logic [PIX_W-1:0]  pix;
  } wr_entry_t;

  localparam fb_addr_t FB_SIZE_A = fb_addr_t'(FB_PIXELS);
  localparam fb_addr_t FB_LAST_A = fb_addr_t'(FB_PIXELS - 1);

  // line*640 + offset as a shift-add; only valid for H_RES == 640
  function automatic fb_addr_t pix_addr(input logic [LINE_W-1:0] line,
                                        input logic [OFFS_W-1:0] offs);
    fb_addr_t l;
    l = fb_addr_t'(line);
    return (l << 9) + (l << 7) + fb_addr_t'(offs);
  endfunction

  function automatic logic vga_oor(input logic [LINE_W-1:0] line,
                                   input logic [OFFS_W-1:0] offs);
    return (line >= LINE_W'(V_RES)) || (offs >= OFFS_W'(H_RES));
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle around the arbiter: VGA fetch, CPU write, RAM and clear control.
// slave = arbiter side, master = surrounding system.
interface vga_fb_arbiter_if;
  import vga_pkg::*;

  logic                vga_req;
  logic [LINE_W-1:0]   vga_line;
  logic [OFFS_W-1:0]   vga_offset;
  logic [PIX_W-1:0]    vga_rgb;

  logic                cpu_valid;
  logic                cpu_ready;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [PIX_W-1:0]    cpu_wdata;
  logic                cpu_err;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [PIX_W-1:0]    mem_wdata;
  logic [PIX_W-1:0]    mem_rdata;

  logic                clr_start;
  logic                clr_busy;

  modport slave (
    input  vga_req, vga_line, vga_offset, cpu_valid, cpu_addr, cpu_wdata,
           mem_rdata, clr_start,
    output vga_rgb, cpu_ready, cpu_err, mem_en, mem_we, mem_addr, mem_wdata,
           clr_busy
  );

  modport master (
    output vga_req, vga_line, vga_offset, cpu_valid, cpu_addr, cpu_wdata,
           mem_rdata, clr_start,
    input  vga_rgb, cpu_ready, cpu_err, mem_en, mem_we, mem_addr, mem_wdata,
           clr_busy
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// CPU write buffer: synchronous FIFO, no fall-through.
// full is registered from the next-state occupancy so it is never stale.
module fb_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             r_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !r_full;
  assign w_do_pop  = pop && (r_count != '0);

  // next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)
      w_count_nxt = r_count + (PTR_W+1)'(1);
    else if (!w_do_push && w_do_pop)
      w_count_nxt = r_count - (PTR_W+1)'(1);
  end

  // pointers, occupancy and full flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PTR_W+1)'(DEPTH));
    end
  end

  // storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = (r_count == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA fetch (strict priority), optional
// clear sweep, then buffered CPU writes.
// Build option: FB_CLEAR_EN enables the clear sweep (clr_start/clr_busy).
//
// Grant state (registered, drives the RAM port for one cycle):
//   state    | meaning
//   GNT_NONE | RAM idle
//   GNT_VGA  | pixel read for display (disabled if request out of range)
//   GNT_CPU  | FIFO head written (dropped with cpu_err if address out of range)
//   GNT_CLR  | clear sweep writes 0 to the current clear address
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input logic               clk,
  input logic               reset,
  vga_fb_arbiter_if.slave   bus
);

  gnt_t       r_gnt;
  gnt_t       w_gnt_nxt;
  fb_addr_t   r_addr;
  logic [PIX_W-1:0] r_wdata;
  logic       r_oor;
  logic       r_ready_en;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [$bits(wr_entry_t)-1:0] w_fifo_dout;
  wr_entry_t  w_head;
  fb_addr_t   w_vga_addr;
  logic       w_vga_oor;
  logic       w_cpu_oor;
  logic       w_clr_act;
  fb_addr_t   w_clr_addr;

  logic       w_mem_en;
  logic       w_mem_we;
  logic       w_cpu_err;

  logic [RD_LAT:0]  r_vpipe;
  logic [RD_LAT:0]  r_voor;
  logic [PIX_W-1:0] r_rgb;

  assign w_vga_addr = pix_addr(bus.vga_line, bus.vga_offset);
  assign w_vga_oor  = vga_oor(bus.vga_line, bus.vga_offset);
  assign w_head     = wr_entry_t'(w_fifo_dout);
  assign w_cpu_oor  = (w_head.addr >= FB_SIZE_A);

  assign w_push = bus.cpu_valid && bus.cpu_ready;
  assign w_pop  = (w_gnt_nxt == GNT_CPU);

  fb_wr_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({bus.cpu_addr, bus.cpu_wdata}),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef FB_CLEAR_EN
  logic     r_clr_busy;
  fb_addr_t r_clr_addr;

  // clear sweep: start is ignored while busy, ends after the last pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_busy <= 1'b0;
      r_clr_addr <= '0;
    end else if (!r_clr_busy) begin
      if (bus.clr_start) begin
        r_clr_busy <= 1'b1;
        r_clr_addr <= '0;
      end
    end else if (w_gnt_nxt == GNT_CLR) begin
      if (r_clr_addr == FB_LAST_A) r_clr_busy <= 1'b0;
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  assign w_clr_act    = r_clr_busy;
  assign w_clr_addr   = r_clr_addr;
  assign bus.clr_busy = r_clr_busy;
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clr_start;
  assign w_clr_act    = 1'b0;
  assign w_clr_addr   = '0;
  assign bus.clr_busy = 1'b0;
`endif

  // grant state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_gnt <= GNT_NONE;
    else       r_gnt <= w_gnt_nxt;
  end

  // fixed-priority grant decision: VGA > clear > CPU
  always_comb begin
    w_gnt_nxt = GNT_NONE;
    if (bus.vga_req)   w_gnt_nxt = GNT_VGA;
    else if (w_clr_act) w_gnt_nxt = GNT_CLR;
    else if (!w_empty)  w_gnt_nxt = GNT_CPU;
  end

  // RAM strobes and error pulse for the granted access
  always_comb begin
    w_mem_en  = 1'b0;
    w_mem_we  = 1'b0;
    w_cpu_err = 1'b0;
    case (r_gnt)
      GNT_VGA: w_mem_en = !r_oor;
      GNT_CPU: begin
        w_mem_en  = !r_oor;
        w_mem_we  = !r_oor;
        w_cpu_err = r_oor;
      end
      GNT_CLR: begin
        w_mem_en = 1'b1;
        w_mem_we = 1'b1;
      end
      default: ;
    endcase
  end

  // capture address/data of the winner; address holds when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_oor   <= 1'b0;
    end else begin
      case (w_gnt_nxt)
        GNT_VGA: begin
          r_addr  <= w_vga_addr;
          r_wdata <= '0;
          r_oor   <= w_vga_oor;
        end
        GNT_CPU: begin
          r_addr  <= w_head.addr;
          r_wdata <= w_head.pix;
          r_oor   <= w_cpu_oor;
        end
        GNT_CLR: begin
          r_addr  <= w_clr_addr;
          r_wdata <= '0;
          r_oor   <= 1'b0;
        end
        default: r_oor <= 1'b0;
      endcase
    end
  end

  // read pipeline: stage RD_LAT lines up with mem_rdata; out-of-range gives 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vpipe <= '0;
      r_voor  <= '0;
      r_rgb   <= '0;
    end else begin
      r_vpipe[0] <= bus.vga_req;
      r_voor[0]  <= w_vga_oor;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_voor[i]  <= r_voor[i-1];
      end
      if (r_vpipe[RD_LAT])
        r_rgb <= r_voor[RD_LAT] ? '0 : bus.mem_rdata;
    end
  end

  // holds cpu_ready low while reset is asserted, rises one cycle after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ready_en <= 1'b0;
    else       r_ready_en <= 1'b1;
  end

  assign bus.cpu_ready = r_ready_en && !w_full;
  assign bus.cpu_err   = w_cpu_err;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.vga_rgb   = r_rgb;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter. The RAM model returns addr[2:0] on reads.
// Build option: FB_CLEAR_EN selects the clear-sweep scenario.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_wr  = 0;
  int   w0;
  logic [2:0] ram_q = '0;

  vga_fb_arbiter_if bus();

  vga_fb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // read-only RAM model: data = low address bits, one cycle latency
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) ram_q <= bus.mem_addr[2:0];
  end
  assign bus.mem_rdata = ram_q;

  // count every RAM write cycle
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) n_wr <= n_wr + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int wa[4] = '{100, 200, 300, 307199};
  int wd[4] = '{1, 2, 4, 7};

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_clr;
    int nz;
    int last_a;

    bus.vga_req = 0; bus.vga_line = '0; bus.vga_offset = '0;
    bus.cpu_valid = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 0;

    // reset state
    tick; tick;
    chk("rst_rgb",   bus.vga_rgb, 0);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_en",    bus.mem_en, 0);
    chk("rst_err",   bus.cpu_err, 0);
    chk("rst_busy",  bus.clr_busy, 0);
    reset = 0;
    tick;
    chk("ready_after_rst", bus.cpu_ready, 1);

    // VGA read line 2 offset 5 -> 1285, RAM data 5
    bus.vga_req = 1; bus.vga_line = 9'd2; bus.vga_offset = 10'd5;
    tick;
    chk("vga_en",   bus.mem_en, 1);
    chk("vga_we",   bus.mem_we, 0);
    chk("vga_addr", bus.mem_addr, 1285);
    bus.vga_req = 0;
    tick;
    chk("vga_rgb_early", bus.vga_rgb, 0);
    tick;
    chk("vga_rgb", bus.vga_rgb, 5);
    tick;
    chk("vga_rgb_hold", bus.vga_rgb, 5);

    // out-of-range offset 640: no access, zero pixel
    bus.vga_req = 1; bus.vga_line = 9'd0; bus.vga_offset = 10'd640;
    tick;
    chk("oor_en", bus.mem_en, 0);
    bus.vga_req = 0;
    tick; tick;
    chk("oor_rgb", bus.vga_rgb, 0);

    // last valid CPU address is written
    bus.cpu_valid = 1; bus.cpu_addr = 19'd307199; bus.cpu_wdata = 3'd3;
    tick;
    bus.cpu_valid = 0;
    tick;
    chk("cpu_last_en",   bus.mem_en, 1);
    chk("cpu_last_we",   bus.mem_we, 1);
    chk("cpu_last_addr", bus.mem_addr, 307199);
    chk("cpu_last_data", bus.mem_wdata, 3);
    chk("cpu_last_err",  bus.cpu_err, 0);

    // first invalid CPU address: dropped with a one-cycle error
    bus.cpu_valid = 1; bus.cpu_addr = 19'd307200; bus.cpu_wdata = 3'd6;
    tick;
    bus.cpu_valid = 0;
    tick;
    chk("cpu_oor_en",  bus.mem_en, 0);
    chk("cpu_oor_err", bus.cpu_err, 1);
    tick;
    chk("cpu_oor_err_end", bus.cpu_err, 0);

    // VGA priority: 10 cycles of vga_req while 4 writes are queued
    bus.vga_req = 1; bus.vga_line = 9'd1; bus.vga_offset = 10'd3;
    chk("prio_ready_start", bus.cpu_ready, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        bus.cpu_valid = 1; bus.cpu_addr = 19'(wa[i]); bus.cpu_wdata = 3'(wd[i]);
      end else begin
        bus.cpu_valid = 0;
      end
      tick;
      chk("prio_no_we", bus.mem_we, 0);
      if (i == 3) chk("prio_ready_full", bus.cpu_ready, 0);
    end
    bus.vga_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("drain_we",   bus.mem_we, 1);
      chk("drain_addr", bus.mem_addr, wa[i]);
      chk("drain_data", bus.mem_wdata, wd[i]);
      if (i == 0) chk("drain_ready", bus.cpu_ready, 1);
    end
    tick;
    chk("drain_idle", bus.mem_we, 0);
    chk("prio_rgb", bus.vga_rgb, 3);

    // reset mid-operation with 3 writes queued behind VGA
    bus.vga_req = 1; bus.vga_line = 9'd1; bus.vga_offset = 10'd3;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_valid = 1; bus.cpu_addr = 19'(10 + i); bus.cpu_wdata = 3'(5);
      tick;
    end
    bus.cpu_valid = 0;
    tick; tick;
    chk("pre_rst_en",   bus.mem_en, 1);
    chk("pre_rst_addr", bus.mem_addr, 643);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_rgb",   bus.vga_rgb, 0);
    chk("mid_rst_ready", bus.cpu_ready, 0);
    chk("mid_rst_en",    bus.mem_en, 0);
    chk("mid_rst_we",    bus.mem_we, 0);
    chk("mid_rst_addr",  bus.mem_addr, 0);
    chk("mid_rst_err",   bus.cpu_err, 0);
    bus.vga_req = 0;
    @(posedge clk);
    #1;
    reset = 0;
    w0 = n_wr;
    tick;
    chk("post_rst_ready", bus.cpu_ready, 1);
    repeat (5) tick;
    chk("post_rst_no_wr", n_wr - w0, 0);
    chk("post_rst_we",    bus.mem_we, 0);

`ifdef FB_CLEAR_EN
    bus.clr_start = 1;
    tick;
    bus.clr_start = 0;
    chk("clr_busy_set", bus.clr_busy, 1);
    tick;
    chk("clr_first_we",   bus.mem_we, 1);
    chk("clr_first_addr", bus.mem_addr, 0);
    chk("clr_first_data", bus.mem_wdata, 0);
    bus.clr_start = 1;
    tick;
    bus.clr_start = 0;
    tick;
    chk("clr_restart_ignored", bus.mem_addr, 2);
    n_clr = 3;
    nz = 0;
    last_a = 2;
    for (int i = 0; i < 310000 && bus.clr_busy === 1'b1; i++) begin
      tick;
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
        n_clr++;
        last_a = int'(bus.mem_addr);
        if (bus.mem_wdata !== 3'd0) nz++;
      end
    end
    chk("clr_done",    bus.clr_busy, 0);
    chk("clr_count",   n_clr, 307200);
    chk("clr_last",    last_a, 307199);
    chk("clr_nonzero", nz, 0);
    tick;
    chk("clr_idle_we", bus.mem_we, 0);
`else
    bus.clr_start = 1;
    tick;
    bus.clr_start = 0;
    chk("clr_off_busy", bus.clr_busy, 0);
    tick;
    chk("clr_off_en", bus.mem_en, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
